// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared constants, state type and helpers for the shift-add multiplier
package multiplier_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold the value WIDTH itself, hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multiplier_datapath.sv
// rtl/multiplier_datapath.sv - accumulator, shift register, adder and sign fix-up
// Sign handling is only exercised when the top is built with MULTIPLIER_SIGNED_EN.
module multiplier_datapath
  import multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;

  always_comb begin
    // Upper half plus optional multiplicand, carry kept in bit WIDTH and shifted in.
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    shifted = {sum, acc_q[WIDTH-1:1]};
    result  = neg_q ? (~shifted + 1'b1) : shifted;

    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    if (load) begin
      mcand_d = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
      acc_d   = {{WIDTH{1'b0}}, ((signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b)};
      neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc_d   = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
    end
  end

endmodule

// File: rtl/multiplier.sv
// rtl/multiplier.sv - iterative shift-add multiplier with start/done handshake
// Optional signed mode (signed_op port) enabled by MULTIPLIER_SIGNED_EN.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MULTIPLIER_SIGNED_EN
  input  logic                 signed_op,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;
  logic [2*WIDTH-1:0] result;
  logic               accept;
  logic               step;
  logic               sop;

`ifdef MULTIPLIER_SIGNED_EN
  assign sop = signed_op;
`else
  assign sop = 1'b0;
`endif

  assign accept = start && (state_q != BUSY);
  assign step   = (state_q == BUSY);

  multiplier_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (step),
    .signed_op (sop),
    .a         (a),
    .b         (b),
    .result    (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= BUSY;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          // Last iteration: the datapath's combinational result already includes it.
          if (cnt_q == CW'(1)) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= result;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - self-checking randomized bench for the shift-add multiplier
module tb_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           signed_op = 1'b0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef MULTIPLIER_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return 64'(x) * 64'(y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation and reports product and edges from accept to done (-1 on timeout).
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [2*W-1:0] p, output int lat);
    a = x; b = y; signed_op = s; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    p = product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", done); end
    checks++; if (product !== '0) begin errors++; $display("FAIL reset_product got=%0h want=0", product); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    int busy_cycles;
    a = 5; b = 3; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_accept got=%0b want=1", busy); end
    busy_cycles = 1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done) begin lat = i; break; end
      if (busy) busy_cycles++;
      if (product !== '0) begin
        checks++; errors++;
        $display("FAIL basic_product_during_busy got=%0h want=0", product);
      end
    end
    checks++; if (lat != W) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", lat, W); end
    checks++; if (busy_cycles != W) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=%0d", busy_cycles, W); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%0b want=0", busy); end
    checks++; if (product !== 64'd15) begin errors++; $display("FAIL basic_product got=%0d want=15", product); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%0b want=0", done); end
    tick(); tick();
    checks++; if (product !== 64'd15) begin errors++; $display("FAIL basic_product_hold got=%0d want=15", product); end
  endtask

  task automatic test_directed();
    logic [W-1:0]   xs [7] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd123456789, 32'd12345, 32'hFFFFFFF6};
    logic [W-1:0]   ys [7] = '{32'd12345, 32'd0, 32'd2, 32'hFFFFFFFF, 32'd987654321, 32'd6789, 32'd20};
    logic [2*W-1:0] ex [7] = '{64'd0, 64'd0, 64'd8589934590, 64'd4294967295,
                               64'd121932631112635269, 64'd83810205, 64'd85899345720};
    logic [2*W-1:0] p;
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(xs[i], ys[i], 1'b0, p, lat);
      checks++; if (lat != W) begin errors++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, W); end
      checks++; if (p !== ex[i]) begin errors++; $display("FAIL directed%0d_product got=%0d want=%0d", i, p, ex[i]); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [W-1:0]   x, y;
    logic [2*W-1:0] p, e;
    int lat;
    for (int i = 0; i < 25; i++) begin
      x = $urandom(); y = $urandom();
      if (i % 5 == 0) y = $urandom_range(0, 15);
      e = ref_mul(x, y, 1'b0);
      do_op(x, y, 1'b0, p, lat);
      checks++;
      if (lat != W || p !== e) begin
        errors++;
        $display("FAIL random%0d a=%0h b=%0h got=%0h lat=%0d want=%0h lat=%0d", i, x, y, p, lat, e, W);
      end
      if (i % 2 == 0) tick();
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    a = 7; b = 9; start = 1'b1;
    tick();
    a = 1000; b = 2000;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) lat = i;
    end
    start = 1'b0;
    for (int i = 21; i <= 100 && lat < 0; i++) begin
      tick();
      if (done) lat = i;
    end
    checks++; if (lat != W) begin errors++; $display("FAIL busy_start_latency got=%0d want=%0d", lat, W); end
    checks++; if (product !== 64'd63) begin errors++; $display("FAIL busy_start_product got=%0d want=63", product); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] p, e;
    int lat;
    do_op(32'd11, 32'd13, 1'b0, p, lat);
    checks++; if (p !== 64'd143) begin errors++; $display("FAIL b2b_first got=%0d want=143", p); end
    a = $urandom(); b = $urandom(); start = 1'b1;
    e = ref_mul(a, b, 1'b0);
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept busy=%0b done=%0b want busy=1 done=0", busy, done); end
    checks++; if (product !== 64'd143) begin errors++; $display("FAIL b2b_hold got=%0d want=143", product); end
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done) begin lat = i; break; end
    end
    checks++; if (lat != W) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", lat, W); end
    checks++; if (product !== e) begin errors++; $display("FAIL b2b_product got=%0h want=%0h", product, e); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    a = 32'hDEAD; b = 32'hBEEF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%0b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got=%0b want=0", done); end
    checks++; if (product !== '0) begin errors++; $display("FAIL midreset_product got=%0h want=0", product); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_activity got=%0d want=0", seen); end
  endtask

`ifdef MULTIPLIER_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0]   x, y;
    logic [2*W-1:0] p, e;
    int lat;
    do_op(32'hFFFFFFF6, 32'd20, 1'b1, p, lat);
    checks++; if (p !== 64'hFFFFFFFFFFFFFF38 || lat != W) begin errors++; $display("FAIL signed_m10x20 got=%0h lat=%0d want=ffffffffffffff38", p, lat); end
    do_op(32'h80000000, 32'h80000000, 1'b1, p, lat);
    checks++; if (p !== 64'h4000000000000000) begin errors++; $display("FAIL signed_minsq got=%0h want=4000000000000000", p); end
    do_op(32'hFFFFFFF6, 32'd20, 1'b0, p, lat);
    checks++; if (p !== 64'd85899345720) begin errors++; $display("FAIL signed_off got=%0d want=85899345720", p); end
    for (int i = 0; i < 20; i++) begin
      x = $urandom(); y = $urandom();
      e = ref_mul(x, y, 1'b1);
      do_op(x, y, 1'b1, p, lat);
      checks++;
      if (p !== e || lat != W) begin errors++; $display("FAIL signed_rand%0d a=%0h b=%0h got=%0h want=%0h", i, x, y, p, e); end
    end
    signed_op = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef MULTIPLIER_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
